mem_access_unit: RTL

- MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the registered MemRead/MemWrite/loadtype/storetype controls, the ALU result as the address, and B as the store data.
- Drives a request/ready data-memory bus with byte strobes and produces sign/zero-extended load data for MEM/WB.
- Holds the pipeline via mem_stall until each access completes.

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a registered load/store into one request/ready
// bus access, holds the pipeline until it completes and extends the load result.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  loadtype,
  input  logic [1:0]  storetype,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        misalign,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        req_q, we_q, done_q, misalign_q, bus_err_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  ltype_q;
  logic [1:0]  lane_q;

  logic        op, is_word, is_half, misal;
  logic [1:0]  lane;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, addr_d;

  function automatic logic [31:0] extend(input logic [2:0] lt, input logic [1:0] lane_sel,
                                         input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rd >> {lane_sel, 3'b000};
    b  = sh[7:0];
    h  = lane_sel[1] ? rd[31:16] : rd[15:0];
    case (lt)
      3'd1:    extend = {{24{b[7]}}, b};
      3'd2:    extend = {24'd0, b};
      3'd3:    extend = {{16{h[15]}}, h};
      3'd4:    extend = {16'd0, h};
      default: extend = rd;
    endcase
  endfunction

  // A store takes precedence over a simultaneous load, so sizing follows MemWrite.
  always_comb begin
    lane    = addr_in[1:0];
    op      = MemWrite | MemRead;
    is_word = MemWrite ? (storetype == 2'd0 || storetype == 2'd3)
                       : !(loadtype inside {[3'd1:3'd4]});
    is_half = MemWrite ? (storetype == 2'd2) : (loadtype == 3'd3 || loadtype == 3'd4);
    misal   = (is_word && lane != 2'b00) || (is_half && lane[0]);
    addr_d  = {addr_in[31:2], 2'b00};
    wstrb_d = 4'b0000;
    wdata_d = wdata_in;
    if (MemWrite) begin
      case (storetype)
        2'd1: begin
          wstrb_d = 4'b0001 << lane;
          wdata_d = {4{wdata_in[7:0]}};
        end
        2'd2: begin
          wstrb_d = lane[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata_in[15:0]}};
        end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  // DONE exists only to let EX/MEM advance past the operation just serviced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      load_q     <= 32'd0;
      ltype_q    <= 3'd0;
      lane_q     <= 2'd0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op && misal) begin
            misalign_q <= 1'b1;
          end else if (op) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            ltype_q <= loadtype;
            lane_q  <= lane;
            cnt_q   <= 8'd0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q) load_q <= extend(ltype_q, lane_q, mem_rdata);
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            load_q    <= 32'd0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_stall = (state_q == S_WAIT) || (state_q == S_IDLE && op && !misal);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_q;
  assign mem_done  = done_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
endmodule
